uart_rx_tx_bridge_fifo: RTL and testbench
=========================================

Name: uart_rx_tx_bridge_fifo

Overview:
Byte buffer and transmit sequencer between the UART receiver and the UART transmitter inside the lab top level. It captures each received byte on the receiver's one-cycle data-ready strobe and stores it in a FIFO. It replays the bytes in order to the transmitter through the start/busy handshake, giving a loss-free echo path when bytes arrive faster than the transmitter drains them. Target clock is clk at 25 MHz, with a bit time of 432 clocks.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
DATA_W, 8, byte width.
BUSY_TIMEOUT, 15, maximum number of WAIT_RISE cycles spent waiting for tx_busy to rise before the byte is treated as sent.

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high.
rx_data_ready  in  1  one-cycle strobe from the receiver; rx_data is valid while it is high.
rx_data  in  DATA_W  received byte.
tx_busy  in  1  transmitter busy flag.
tx_start  out  1  one-cycle start pulse to the transmitter.
tx_data  out  DATA_W  byte presented to the transmitter.
fifo_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
fifo_empty  out  1  high when fifo_count = 0.
fifo_full  out  1  high when fifo_count = DEPTH.
overflow  out  1  sticky flag: a received byte was dropped because the FIFO was full.
ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (synchronous, active-high, clk only):
  - wr_ptr, rd_ptr and count are cleared.
  - FSM goes to IDLE.
  - Outputs: tx_start=0, tx_data=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - Reset has priority over every other input.
  - Reset in the middle of a transmission drops the byte in flight and all queued bytes. tx_start stays low, and the transmitter finishes its current frame on its own.
- Write:
  - On a rising edge with rx_data_ready=1 and not full: mem[wr_ptr] <= rx_data, wr_ptr increments modulo DEPTH, count increments.
  - If full: the byte is discarded, pointers and count are unchanged, and overflow is set.
- Overflow flag:
  - ovf_clr=1 clears overflow on the next edge.
  - If ovf_clr and a dropped write happen in the same cycle, overflow stays set (set wins).
- Read and transmit FSM, states IDLE, LAUNCH, WAIT_RISE, WAIT_FALL:
  - IDLE: if count != 0 and tx_busy=0, go to LAUNCH. On that same edge, tx_data <= mem[rd_ptr], rd_ptr increments and count decrements.
  - LAUNCH: tx_start=1 for exactly this one cycle; next state is WAIT_RISE.
  - WAIT_RISE: on tx_busy=1 go to WAIT_FALL. If tx_busy is still 0 after BUSY_TIMEOUT cycles in this state, go to IDLE.
  - WAIT_FALL: on tx_busy=0 go to IDLE.
  - tx_data is held stable from the LAUNCH entry edge until the next LAUNCH.
  - tx_start is registered and is low in every state except LAUNCH.
- Latency:
  - rx_data_ready sampled at edge k into an empty FIFO with an idle transmitter: fifo_count=1 after edge k.
  - Edge k+1: FSM enters LAUNCH and count returns to 0.
  - tx_start is high in the cycle following edge k+1.
- Simultaneous write and pop (same edge): both happen and count is unchanged.
  - When full: the pop frees a slot, but the write is still judged against the pre-edge full state. The byte is dropped and overflow is set.
  - When empty: no pop occurs, because the pop uses the pre-edge count.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer comparison.
- Flags: fifo_empty and fifo_full are combinational decodes of the registered count.

Decomposition:
- Shared package uart_pkg: DATA_W default, the BIT_CLKS=432 constant, and the tx FSM state enum (IDLE, LAUNCH, WAIT_RISE, WAIT_FALL).
- One sub-module, byte_sync_fifo: memory, pointers, count, full/empty and overflow logic, with push/pop/dout ports.
- The top of this block holds the transmit FSM and the timeout counter.

Test Plan:
- Single byte: after reset, strobe rx_data=0x58 for 1 cycle. Required: fifo_count goes 0→1→0, tx_start is high exactly 1 cycle (2 clocks after the strobe), tx_data=0x58. Bench model raises busy for 4320 clocks and no second start occurs.
- Burst ordering: write 0x11, 0x22, 0x33 on consecutive cycles while tx_busy is held high. Required: fifo_count=3. After busy drops, three start pulses occur with tx_data 0x11, 0x22, 0x33 in order, each after a busy rise/fall cycle.
- Full and overflow: with tx_busy stuck high, write 17 bytes 0x00..0x10. Required: fifo_full=1, fifo_count=16, overflow=1, and 0x10 is never transmitted. ovf_clr pulse then sets overflow=0.
- Simultaneous write and pop: count=1, and a write of 0xA5 coincides with the IDLE→LAUNCH edge. Required: fifo_count stays 1 and 0xA5 is sent next.
- Busy timeout: tx_busy tied low. Write 0x7E. Required: one tx_start pulse, return to IDLE after 15 WAIT_RISE cycles, FIFO empty, no hang.
- Reset mid-operation: assert rst for 1 cycle while in WAIT_FALL with 5 bytes queued. Required: next cycle fifo_count=0, tx_start=0, overflow=0, tx_data=0, and no further start pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART lab definitions: byte width, bit timing and the transmit
// sequencer state set used by the rx-to-tx bridge.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BIT_CLKS   = 432;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } tx_state_t;

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock byte FIFO with occupancy count, count-derived flags and a
// sticky overflow flag for pushes that arrive while full.
module byte_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Both decisions use the pre-edge count, so a pop never makes room for a
  // push on the same edge and a push never feeds a pop on the same edge.
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_tx_bridge_fifo.sv
// Buffers bytes from the UART receiver and replays them in order to the UART
// transmitter through a start/busy handshake with a busy-rise timeout.
module uart_rx_tx_bridge_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_data_ready,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t         state;
  logic [TW-1:0]     rise_cnt;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;

  assign pop = (state == IDLE) && !fifo_empty && !tx_busy;

  byte_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_data_ready),
    .din      (rx_data),
    .pop      (pop),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // tx_start is raised on the edge entering LAUNCH so it is high for exactly
  // the LAUNCH cycle; tx_data only changes on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      rise_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= fifo_dout;
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          rise_cnt <= '0;
          state    <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (tx_busy) begin
            state <= WAIT_FALL;
          end else if (rise_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            rise_cnt <= rise_cnt + TW'(1);
          end
        end
        WAIT_FALL: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_tx_bridge_fifo.sv
// Self-checking bench for uart_rx_tx_bridge_fifo: vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_uart_rx_tx_bridge_fifo;

  localparam int DEPTH = 16;
  localparam int TO    = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic       ovf_clr;

  uart_rx_tx_bridge_fifo #(
    .DEPTH        (DEPTH),
    .DATA_W       (8),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] d;
    logic       busy;
    logic       clr;
    int         cnt;
    logic       start;
    logic [7:0] data;
    logic       ovf;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  vec_t vq[$];
  int   got_q[$];
  int   got_t[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic [7:0] d,
                              input logic busy, input logic clr, input int cnt,
                              input logic start, input logic [7:0] data, input logic ovf);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.d = d; v.busy = busy; v.clr = clr;
    v.cnt = cnt; v.start = start; v.data = data; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_in();
    rst = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    tx_busy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    rx_data_ready = 1'b1;
    rx_data = b;
    step();
    rx_data_ready = 1'b0;
  endtask

  // Transmitter stand-in: after each observed start, busy is high for busy_len edges.
  task automatic run_tx(input int max_cyc, input int busy_len, input int init_left);
    int left;
    left = init_left;
    got_q.delete();
    got_t.delete();
    for (int i = 0; i < max_cyc; i++) begin
      tx_busy = (left > 0);
      step();
      if (left > 0) left--;
      if (tx_start) begin
        got_q.push_back(int'(tx_data));
        got_t.push_back(cyc);
        left = busy_len;
      end
    end
    tx_busy = 1'b0;
  endtask

  // Reference model state
  int       mq[$];
  bit       m_ready;
  int       m_since;
  bit       m_rose;
  bit       m_ovf;
  bit       m_start;
  int       m_data;

  task automatic model_edge(input bit r, input bit rdy, input int d, input bit busy, input bit clr);
    bit full_pre;
    if (r) begin
      mq.delete();
      m_ready = 1; m_since = 0; m_rose = 0; m_ovf = 0; m_start = 0; m_data = 0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      m_start  = 0;
      if (m_ready && mq.size() != 0 && !busy) begin
        m_data  = mq.pop_front();
        m_start = 1;
        m_ready = 0;
        m_since = 0;
        m_rose  = 0;
      end else if (!m_ready) begin
        m_since++;
        if (m_since >= 2) begin
          if (!m_rose) begin
            if (busy) m_rose = 1;
            else if (m_since - 1 == TO) m_ready = 1;
          end else if (!busy) begin
            m_ready = 1;
          end
        end
      end
      if (rdy && full_pre) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (rdy && !full_pre) mq.push_back(d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit busy_r;
    int hold;
    bit r_rst, r_rdy, r_clr;
    int r_d, rate;

    rst = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; ovf_clr = 1'b0;

    // ---- vector table: rst rdy d busy clr | cnt start data ovf
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    vq.push_back(mk(0, 1, 8'h58, 0, 0, 1, 0, 8'h00, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h58, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h58, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h58, 0));
    vq.push_back(mk(0, 1, 8'hA5, 1, 0, 1, 0, 8'h58, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h58, 0));
    vq.push_back(mk(0, 1, 8'h3C, 0, 0, 1, 1, 8'hA5, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 8'hA5, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h3C, 0));
    foreach (vq[i]) begin
      rst = vq[i].rst; rx_data_ready = vq[i].rdy; rx_data = vq[i].d;
      tx_busy = vq[i].busy; ovf_clr = vq[i].clr;
      step();
      chk($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vq[i].cnt));
      chk($sformatf("vec%0d.start", i), 32'(tx_start), 32'(vq[i].start));
      chk($sformatf("vec%0d.data", i), 32'(tx_data), 32'(vq[i].data));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vq[i].ovf));
      chk($sformatf("vec%0d.empty", i), 32'(fifo_empty), 32'(vq[i].cnt == 0));
    end

    // ---- single byte with a 10-bit-time busy frame
    do_reset();
    chk("single.reset_count", 32'(fifo_count), 0);
    chk("single.reset_empty", 32'(fifo_empty), 1);
    chk("single.reset_full", 32'(fifo_full), 0);
    write_byte(8'h58);
    chk("single.count_k", 32'(fifo_count), 1);
    chk("single.start_k", 32'(tx_start), 0);
    step();
    chk("single.count_k1", 32'(fifo_count), 0);
    chk("single.start_k1", 32'(tx_start), 1);
    chk("single.data", 32'(tx_data), 32'h58);
    run_tx(4400, 4320, 4320);
    chk("single.extra_starts", 32'(got_q.size()), 0);
    chk("single.data_held", 32'(tx_data), 32'h58);

    // ---- burst ordering
    do_reset();
    tx_busy = 1'b1;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    chk("burst.count", 32'(fifo_count), 3);
    run_tx(300, 20, 0);
    chk("burst.n_starts", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("burst.byte0", 32'(got_q[0]), 32'h11);
      chk("burst.byte1", 32'(got_q[1]), 32'h22);
      chk("burst.byte2", 32'(got_q[2]), 32'h33);
    end
    chk("burst.empty", 32'(fifo_empty), 1);

    // ---- full and overflow
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) write_byte(8'(i));
    chk("full.count", 32'(fifo_count), 16);
    chk("full.full", 32'(fifo_full), 1);
    chk("full.empty", 32'(fifo_empty), 0);
    chk("full.ovf", 32'(overflow), 1);
    rx_data_ready = 1'b1; rx_data = 8'h99; ovf_clr = 1'b1;
    step();
    idle_in();
    chk("full.set_wins", 32'(overflow), 1);
    chk("full.count_after_drop", 32'(fifo_count), 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("full.ovf_clr", 32'(overflow), 0);
    run_tx(800, 20, 0);
    chk("full.n_drained", 32'(got_q.size()), 16);
    if (got_q.size() == 16) begin
      for (int i = 0; i < 16; i++) chk($sformatf("full.drain%0d", i), 32'(got_q[i]), 32'(i));
    end

    // ---- busy timeout: second byte pops 17 edges after the first
    do_reset();
    write_byte(8'h7E);
    rx_data_ready = 1'b1; rx_data = 8'h7F;
    step();
    idle_in();
    t0 = cyc;
    chk("timeout.start0", 32'(tx_start), 1);
    chk("timeout.data0", 32'(tx_data), 32'h7E);
    chk("timeout.count_pop_push", 32'(fifo_count), 1);
    run_tx(60, 0, 0);
    chk("timeout.n_starts", 32'(got_q.size()), 1);
    if (got_q.size() == 1) begin
      chk("timeout.data1", 32'(got_q[0]), 32'h7F);
      chk("timeout.gap", 32'(got_t[0] - t0), 17);
    end
    chk("timeout.empty", 32'(fifo_empty), 1);

    // ---- reset mid-frame with bytes queued
    do_reset();
    write_byte(8'h40);
    step();
    chk("rstmid.start", 32'(tx_start), 1);
    tx_busy = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) write_byte(8'hB0 + 8'(i));
    chk("rstmid.queued", 32'(fifo_count), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid.count", 32'(fifo_count), 0);
    chk("rstmid.start_low", 32'(tx_start), 0);
    chk("rstmid.ovf", 32'(overflow), 0);
    chk("rstmid.data", 32'(tx_data), 0);
    chk("rstmid.empty", 32'(fifo_empty), 1);
    run_tx(100, 20, 0);
    chk("rstmid.no_starts", 32'(got_q.size()), 0);

    // ---- randomized run against the reference model
    do_reset();
    model_edge(1, 0, 0, 0, 0);
    busy_r = 0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rate  = (i < 1500) ? 60 : 20;
      r_rdy = ($urandom_range(0, 99) < rate);
      r_d   = int'($urandom_range(0, 255));
      r_clr = ($urandom_range(0, 19) == 0);
      r_rst = ($urandom_range(0, 399) == 0);
      if (hold == 0) begin
        busy_r = $urandom_range(0, 1);
        hold = $urandom_range(0, 25);
      end else begin
        hold--;
      end
      model_edge(r_rst, r_rdy, r_d, busy_r, r_clr);
      rst = r_rst; rx_data_ready = r_rdy; rx_data = 8'(r_d); ovf_clr = r_clr; tx_busy = busy_r;
      step();
      chk("rand.count", 32'(fifo_count), 32'(mq.size()));
      chk("rand.start", 32'(tx_start), 32'(m_start));
      chk("rand.data", 32'(tx_data), 32'(m_data));
      chk("rand.ovf", 32'(overflow), 32'(m_ovf));
      chk("rand.full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      chk("rand.empty", 32'(fifo_empty), 32'(mq.size() == 0));
    end
    idle_in();
    tx_busy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
